// File: rtl/uart_mem_cmd_if.sv
// uart_mem_cmd_ctrl_if: UART byte stream, memory port and TX handshake seen by the command controller
interface uart_mem_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64
);
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  write_En;
    logic                  read_En;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] Data_in;
    logic [DATA_WIDTH-1:0] Data_out;
    logic                  Valid_out;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_busy;
    logic                  cmd_err;
    modport master (
        input  rx_data, rx_valid, Data_out, Valid_out, tx_busy,
        output write_En, read_En, Address, Data_in, tx_data, tx_valid, cmd_err
    );
    modport slave (
        output rx_data, rx_valid, Data_out, Valid_out, tx_busy,
        input  write_En, read_En, Address, Data_in, tx_data, tx_valid, cmd_err
    );
endinterface

// File: rtl/uart_mem_cmd_ctrl.sv
// uart_mem_cmd_ctrl: turns UART command bytes into memory writes/reads and streams read words back MSB-first
module uart_mem_cmd_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64
) (
    input logic clk,
    input logic rst,
    uart_mem_cmd_ctrl_if.master bus
);
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = $clog2(NB) + 1;

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_EXEC, RD_EXEC, RD_WAIT, TX_SEND} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic                  wr_q, wr_d, rd_q, rd_d, txv_q, txv_d, err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            sh_q    <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            txv_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sh_q    <= sh_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            txv_q   <= txv_d;
            err_q   <= err_d;
        end
    end

    // Strobes are computed on the transition into the EXEC states so they are high exactly in those states
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sh_d    = sh_q;
        txv_d   = txv_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.rx_valid) begin
                if (bus.rx_data[7:6] == 2'b01) begin
                    addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
                    cnt_d   = '0;
                    state_d = WR_DATA;
                end else if (bus.rx_data[7:6] == 2'b10) begin
                    addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
                    rd_d    = 1'b1;
                    state_d = RD_EXEC;
                end else begin
                    err_d = 1'b1;
                end
            end
            WR_DATA: if (bus.rx_valid) begin
                data_d = (data_q << 8) | DATA_WIDTH'(bus.rx_data);
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(NB - 1)) begin
                    wr_d    = 1'b1;
                    state_d = WR_EXEC;
                end
            end
            WR_EXEC: state_d = IDLE;
            RD_EXEC: state_d = RD_WAIT;
            RD_WAIT: if (bus.Valid_out) begin
                sh_d    = bus.Data_out;
                cnt_d   = '0;
                txv_d   = 1'b1;
                state_d = TX_SEND;
            end else begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            // tx_valid is always high here, so acceptance reduces to !tx_busy
            TX_SEND: if (!bus.tx_busy) begin
                sh_d  = sh_q << 8;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NB - 1)) begin
                    txv_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.rx_valid && state_q != IDLE && state_q != WR_DATA) err_d = 1'b1;
    end

    assign bus.write_En = wr_q;
    assign bus.read_En  = rd_q;
    assign bus.Address  = addr_q;
    assign bus.Data_in  = data_q;
    assign bus.tx_data  = sh_q[DATA_WIDTH-1 -: 8];
    assign bus.tx_valid = txv_q;
    assign bus.cmd_err  = err_q;
endmodule
